multicycle_alu: RTL and testbench

- Parametrised, handshaked successor of the single-cycle 32-bit ALU.
- Covers the same eight logic/arithmetic ops at any DATA_WIDTH, adds barrel shifts and an iterative unsigned multiply.
- Registers Result and flags behind a valid/ready interface, so the CPU datapath can stall on multi-cycle ops.
- Sits between the ID/EX operand latch and the writeback mux.

---
 rtl/multicycle_alu_pkg.sv | 23 ++
 rtl/multicycle_alu_comb_core.sv | 52 +++++
 rtl/multicycle_alu.sv | 148 ++++++++++++++
 tb/tb_multicycle_alu.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_alu_pkg.sv
// multicycle_alu_pkg: opcodes, FSM states and constants shared by multicycle_alu.
// Divider opcodes are only live when MULTICYCLE_ALU_DIVU_EN is defined.
package multicycle_alu_pkg;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    // Quotient returned on divide by zero; sliced to DATA_WIDTH (<= 128) by the user.
    localparam logic [127:0] DIV_BY_ZERO = '1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/multicycle_alu_comb_core.sv
// alu_comb_core: single-cycle logic/add/sub/compare/shift unit of multicycle_alu.
// Unsupported opcodes (multiply, divide, illegal) return zero with clear flags.
module alu_comb_core
    import multicycle_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_overflow,
    output logic                  o_carry
);
    localparam int W = DATA_WIDTH;
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic         w_inv;
    logic [W-1:0] w_bx;
    logic [W:0]   w_sum;
    logic         w_cout;
    logic         w_ovf;
    logic [SHAMT_W-1:0] w_sh;

    assign w_inv  = (i_op == OP_SUB) || (i_op == OP_SLT) || (i_op == OP_SLTU);
    assign w_bx   = w_inv ? ~i_b : i_b;
    assign w_sum  = {i_a[W-1], i_a} + {w_bx[W-1], w_bx} + {{W{1'b0}}, w_inv};
    // Sign-extended sum: carry out of bit W-1 recovered from the extension bit.
    assign w_cout = w_sum[W] ^ i_a[W-1] ^ w_bx[W-1];
    assign w_ovf  = w_sum[W] ^ w_sum[W-1];
    assign w_sh   = i_b[SHAMT_W-1:0];

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_carry    = 1'b0;
        case (i_op)
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_ADD:  begin o_result = w_sum[W-1:0]; o_overflow = w_ovf; o_carry = w_cout; end
            OP_SUB:  begin o_result = w_sum[W-1:0]; o_overflow = w_ovf; o_carry = ~w_cout; end
            OP_SLTU: begin o_result = {{(W-1){1'b0}}, ~w_cout}; o_carry = ~w_cout; end
            OP_SLT:  o_result = {{(W-1){1'b0}}, w_sum[W]};
            OP_SLL:  o_result = i_a << w_sh;
            OP_SRL:  o_result = i_a >> w_sh;
            OP_SRA:  o_result = $unsigned($signed(i_a) >>> w_sh);
            default: o_result = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU with 1-cycle ops and an iterative shift-add multiplier.
// Define MULTICYCLE_ALU_DIVU_EN to add the restoring DIVU/REMU divider.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            ALUop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero
);
    localparam int W = DATA_WIDTH;
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    state_t r_state, w_next;
    logic [W-1:0]       r_result, r_opnd;
    logic               r_ovf, r_carry;
    logic [2*W-1:0]     r_acc;
    logic [SHAMT_W-1:0] r_cnt;

    logic [W-1:0]   w_core_res, w_fin_res;
    logic           w_core_ovf, w_core_carry, w_fin_carry;
    logic           w_accept, w_iter_op, w_is_mul, w_last;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next, w_step_next;

    alu_comb_core #(.DATA_WIDTH(W)) u_core (
        .i_op      (ALUop),
        .i_a       (A),
        .i_b       (B),
        .o_result  (w_core_res),
        .o_overflow(w_core_ovf),
        .o_carry   (w_core_carry)
    );

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_is_mul = ALUop == OP_MULU;
    assign w_last   = r_cnt == SHAMT_W'(W - 1);

    // Multiply: {hi, lo} starts as {0, B}; add A into hi when lo[0] is set, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

`ifdef MULTICYCLE_ALU_DIVU_EN
    logic [3:0]     r_op;
    logic [W+1:0]   w_trial;
    logic [2*W-1:0] w_div_next;
    logic           w_dz;

    assign w_iter_op = w_is_mul || (ALUop == OP_DIVU) || (ALUop == OP_REMU);
    // Divide: {rem, dividend} shifts left; keep the trial difference when it does not borrow.
    assign w_trial    = {1'b0, r_acc[2*W-1:W-1]} - {2'b0, r_opnd};
    assign w_div_next = w_trial[W+1] ? {r_acc[2*W-2:0], 1'b0}
                                     : {w_trial[W-1:0], r_acc[W-2:0], 1'b1};
    assign w_dz       = ~|r_opnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_op <= OP_AND;
        else if (w_accept)
            r_op <= ALUop;
    end

    always_comb begin
        w_step_next = (r_op == OP_MULU) ? w_mul_next : w_div_next;
        w_fin_res   = (r_op == OP_MULU) ? w_mul_next[W-1:0]
                    : (r_op == OP_REMU) ? w_div_next[2*W-1:W]
                    : w_dz ? DIV_BY_ZERO[W-1:0] : w_div_next[W-1:0];
        w_fin_carry = (r_op == OP_MULU) ? |w_mul_next[2*W-1:W] : w_dz;
    end
`else
    assign w_iter_op = w_is_mul;

    always_comb begin
        w_step_next = w_mul_next;
        w_fin_res   = w_mul_next[W-1:0];
        w_fin_carry = |w_mul_next[2*W-1:W];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                w_next   = in_valid ? (w_iter_op ? S_BUSY : S_DONE) : S_IDLE;
            end
            S_BUSY: w_next = w_last ? S_DONE : S_BUSY;
            default: begin
                out_valid = 1'b1;
                w_next    = out_ready ? S_IDLE : S_DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_carry  <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (w_iter_op) begin
                r_opnd <= w_is_mul ? A : B;
                r_acc  <= {{W{1'b0}}, w_is_mul ? B : A};
            end else begin
                r_result <= w_core_res;
                r_ovf    <= w_core_ovf;
                r_carry  <= w_core_carry;
            end
        end else if (r_state == S_BUSY) begin
            r_acc <= w_step_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_fin_res;
                r_ovf    <= 1'b0;
                r_carry  <= w_fin_carry;
            end
        end
    end

    assign Result   = r_result;
    assign Overflow = r_ovf;
    assign CarryOut = r_carry;
    assign Zero     = ~|r_result;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vector table plus stall/reset sequences for multicycle_alu.
// Divider expectations follow MULTICYCLE_ALU_DIVU_EN.
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  ALUop = '0;
    logic        in_ready, out_valid, Overflow, CarryOut, Zero;
    logic [31:0] Result;

    multicycle_alu #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .ALUop    (ALUop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Result   (Result),
        .Overflow (Overflow),
        .CarryOut (CarryOut),
        .Zero     (Zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        cy;
        int          lat;
    } vec_t;

    localparam int NV = 24;
    vec_t vt[NV];
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic rdy_seen;
    logic ov_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Accepts one op and returns at the negedge where out_valid is first seen (or timeout).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        ALUop = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ALUop = OP_ADD;
        A = $urandom;
        B = $urandom;
        lat = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) rdy_seen = 1'b1;
        end while (!out_valid && lat < 200);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vt[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1};
        vt[1]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1};
        vt[2]  = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
        vt[3]  = '{OP_SLTU, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1};
        vt[4]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
        vt[5]  = '{OP_OR,   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1'b0, 1};
        vt[6]  = '{OP_XOR,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1};
        vt[7]  = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vt[8]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1};
        vt[9]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        vt[10] = '{OP_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1};
        vt[11] = '{OP_SRL,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 1};
        vt[12] = '{OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1};
        vt[13] = '{OP_MULU, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 1'b1, 33};
        vt[14] = '{OP_MULU, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0, 1'b0, 33};
        vt[15] = '{OP_MULU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, 1'b1, 33};
        vt[16] = '{4'hE,    32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1};
        vt[17] = '{4'hF,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1};
        vt[18] = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1};
        vt[19] = '{OP_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1};
        vt[20] = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1};
`ifdef MULTICYCLE_ALU_DIVU_EN
        vt[21] = '{OP_DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 33};
        vt[22] = '{OP_REMU, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 33};
        vt[23] = '{OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 33};
`else
        vt[21] = '{OP_DIVU, 32'd100,      32'd7,        32'd0,        1'b0, 1'b0, 1};
        vt[22] = '{OP_REMU, 32'd100,      32'd7,        32'd0,        1'b0, 1'b0, 1};
        vt[23] = '{OP_DIVU, 32'd5,        32'd0,        32'd0,        1'b0, 1'b0, 1};
`endif

        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", {31'b0, Zero}, 32'd1);
        chk("rst_flags", {30'b0, Overflow, CarryOut}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_res", i), Result, vt[i].res);
            chk($sformatf("v%0d_ovf", i), {31'b0, Overflow}, {31'b0, vt[i].ovf});
            chk($sformatf("v%0d_cy", i), {31'b0, CarryOut}, {31'b0, vt[i].cy});
            chk($sformatf("v%0d_zero", i), {31'b0, Zero}, {31'b0, vt[i].res == 32'd0});
            chk($sformatf("v%0d_rdy_busy", i), {31'b0, rdy_seen}, 32'd0);
            chk($sformatf("v%0d_rdy_done", i), {31'b0, in_ready}, 32'd0);
            release_out();
            chk($sformatf("v%0d_idle", i), {30'b0, out_valid, in_ready}, 32'd1);
        end

        // Result held through a stalled consumer; offered inputs must be ignored meanwhile.
        issue(OP_SRA, 32'h80000000, 32'h00000024);
        in_valid = 1'b1;
        ALUop = OP_ADD;
        A = 32'h1;
        B = 32'h1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_res", k), Result, 32'hF8000000);
            chk($sformatf("stall%0d_vld_rdy", k), {30'b0, out_valid, in_ready}, 32'd2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_out();
        chk("stall_idle", {30'b0, out_valid, in_ready}, 32'd1);
        chk("stall_res_kept", Result, 32'hF8000000);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1;
        ALUop = OP_MULU;
        A = 32'd3;
        B = 32'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mul_busy_rdy", {31'b0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_result", Result, 32'd0);
        chk("arst_zero", {31'b0, Zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        chk("arst_no_stale", {31'b0, ov_seen}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        issue(OP_ADD, 32'd2, 32'd3);
        chk("post_rst_lat", lat, 32'd1);
        chk("post_rst_res", Result, 32'd5);
        release_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
